sdpram_pipelined: RTL

- Portable, behavioural simple dual-port RAM for the memory library, with one write port (A) and one read port (B).
- Supersedes the vendor-macro-only wrapper, so the same RTL builds on any simulator or target.
- Generalises the wrapper with byte-lane writes, a parametrised read latency of 1–4, a selectable same-address collision mode, and a read-valid pipeline.
- Used by caches, FIFOs and register-file shadows that run on a single clock domain.

---
 rtl/sdpram_pipelined.sv | 104 ++++++++++
 1 files changed

// File: rtl/sdpram_pipelined.sv
// Behavioural simple dual-port RAM: byte-lane write port A, pipelined read port B.
// Only the read pipeline is reset; the array keeps its contents across rst.
module sdpram_pipelined #(
  parameter int unsigned DATA_DEPTH       = 256,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BYTE_WRITE_WIDTH = 8,
  parameter int unsigned READ_LATENCY     = 2,
  parameter string       WRITE_MODE       = "write_first",
  localparam int unsigned ADDR_WIDTH      = $clog2(DATA_DEPTH),
  localparam int unsigned NUM_LANES       = DATA_WIDTH / BYTE_WRITE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a_i,
  input  logic [NUM_LANES-1:0]  we_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  input  logic                  en_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  output logic [DATA_WIDTH-1:0] data_b_o,
  output logic                  valid_b_o
);

  localparam bit WRITE_FIRST = (WRITE_MODE == "write_first");

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("sdpram_pipelined: READ_LATENCY must be in 1..4");
  end
  if ((DATA_WIDTH % BYTE_WRITE_WIDTH) != 0) begin : g_bad_lanes
    $error("sdpram_pipelined: DATA_WIDTH must be a multiple of BYTE_WRITE_WIDTH");
  end
  if (WRITE_MODE != "write_first" && WRITE_MODE != "read_first") begin : g_bad_mode
    $error("sdpram_pipelined: WRITE_MODE must be write_first or read_first");
  end
  if (DATA_DEPTH < 2) begin : g_bad_depth
    $error("sdpram_pipelined: DATA_DEPTH must be at least 2");
  end

  logic [DATA_WIDTH-1:0]   r_mem [DATA_DEPTH];
  logic [DATA_WIDTH-1:0]   r_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_valid;

  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Addresses past DATA_DEPTH only exist for non-power-of-two depths.
  assign w_wr_in_range = 32'(addr_a_i) < DATA_DEPTH;
  assign w_rd_in_range = 32'(addr_b_i) < DATA_DEPTH;
  assign w_collide     = en_a_i && (addr_a_i == addr_b_i);

  always_ff @(posedge clk) begin
    if (en_a_i && w_wr_in_range) begin
      for (int k = 0; k < int'(NUM_LANES); k++) begin
        if (we_a_i[k]) begin
          r_mem[addr_a_i][k*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] <=
            data_a_i[k*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
        end
      end
    end
  end

  // Stage-0 read word; write_first merges the lanes being written this edge.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      w_rd_word = r_mem[addr_b_i];
      if (WRITE_FIRST && w_collide) begin
        for (int k = 0; k < int'(NUM_LANES); k++) begin
          if (we_a_i[k]) begin
            w_rd_word[k*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] =
              data_a_i[k*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
          end
        end
      end
    end
  end

  // Data stages load only behind a valid bit, so the output holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < int'(READ_LATENCY); k++) begin
        r_data[k] <= '0;
      end
    end else begin
      r_valid[0] <= en_b_i;
      if (en_b_i) begin
        r_data[0] <= w_rd_word;
      end
      for (int k = 1; k < int'(READ_LATENCY); k++) begin
        r_valid[k] <= r_valid[k-1];
        if (r_valid[k-1]) begin
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  assign data_b_o  = r_data[READ_LATENCY-1];
  assign valid_b_o = r_valid[READ_LATENCY-1];

endmodule
